europa_req_arbiter: RTL and testbench
=====================================

EUROPA_REQ_ARBITER -- requirements
Module: europa_req_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter DataWidth, default 64, payload width in bits.
REQ-003 SHALL have parameter TimeoutCycles, default 255, stall cycles before a forced grant release (1..65535).
REQ-004 SHALL have port i_clk  input  1  clock, positive edge triggered.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active high.
REQ-006 SHALL have port i_req_valid  input  NumReq  per-requester beat valid.
REQ-007 SHALL have port i_req_data  input  NumReq x DataWidth  per-requester payload.
REQ-008 SHALL have port i_req_last  input  NumReq  per-requester last beat of transaction.
REQ-009 SHALL have port o_req_ready  output  NumReq  per-requester beat accept.
REQ-010 SHALL have port o_valid  output  1  shared-resource beat valid.
REQ-011 SHALL have port o_data  output  DataWidth  shared-resource payload.
REQ-012 SHALL have port o_last  output  1  shared-resource last beat.
REQ-013 SHALL have port i_ready  input  1  shared-resource beat accept.
REQ-014 SHALL have port o_grant_idx  output  $clog2(NumReq)  index of current owner; 0 when idle.
REQ-015 SHALL have port o_busy  output  1  high while in LOCK.
REQ-016 SHALL have port o_timeout  output  1  one-cycle pulse on forced release.

Function
REQ-017 SHALL implement FSM states IDLE and LOCK.
REQ-018 In IDLE, if any i_req_valid is high, SHALL register the round-robin winner, searching upward from priority pointer ptr with wrap, and enter LOCK next cycle.
REQ-019 In IDLE, all o_req_ready, o_valid and o_last SHALL be 0.
REQ-020 In LOCK with owner g, o_valid, o_data and o_last SHALL equal i_req_valid[g], i_req_data[g] and i_req_last[g] combinationally, o_req_ready[g] SHALL equal i_ready, and all other o_req_ready bits SHALL be 0.
REQ-021 A beat SHALL transfer when o_valid and i_ready are both high; the grant SHALL NOT change mid-transaction.
REQ-022 On a transfer with o_last=1, SHALL return to IDLE next cycle and set ptr to (g+1) mod NumReq; this gives one idle bubble between grants.
REQ-023 A stall counter SHALL clear on entering LOCK and on every transfer, and increment on each other LOCK cycle.
REQ-024 When the stall counter reaches TimeoutCycles, SHALL return to IDLE, set ptr to (g+1) mod NumReq, and pulse o_timeout for 1 cycle.
REQ-025 If a last-beat transfer and timeout coincide, the transfer SHALL win and o_timeout SHALL stay 0.
REQ-026 A requester dropping valid mid-transaction SHALL keep the grant, subject only to timeout.
REQ-027 With a single active requester, back-to-back transactions SHALL be granted every second-or-later cycle after the bubble.

Reset
REQ-028 While i_rst is high, state SHALL be IDLE, ptr 0, stall counter 0, o_grant_idx 0, o_busy 0, o_timeout 0, all o_req_ready 0, o_valid 0 and o_last 0.
REQ-029 Reset asserted mid-transaction SHALL abort the grant with no o_timeout pulse; the first grant after reset SHALL start the search from index 0.

Structure
REQ-030 Package europa_req_arbiter_pkg SHALL hold the state enum (IDLE, LOCK) and the default parameter constants.
REQ-031 The round-robin priority search SHALL be the combinational sub-module europa_rr_picker (inputs req vector and ptr; outputs valid and index).
REQ-032 Only the state, owner, ptr, stall counter and timeout pulse SHALL be registered; there SHALL be no data buffering.

Verification
REQ-033 Scenario 1: NumReq=4, req 0 and 2 both valid from reset, 1-beat transactions, i_ready=1 -> grants 0, 2, 0, 2 alternate, one bubble between grants.
REQ-034 Scenario 2: req 1 sends 3 beats (last on beat 3) while req 3 is valid -> o_grant_idx stays 1 for all 3 beats, then 3 is granted after the bubble.
REQ-035 Scenario 3: TimeoutCycles=4, req 0 granted then drops valid -> o_timeout pulses in the 4th stall cycle, IDLE follows, and the next search starts at index 1.
REQ-036 Scenario 4: TimeoutCycles=4, last beat accepted on the same cycle the counter reaches 4 -> o_timeout=0, normal release.
REQ-037 Scenario 5: i_rst pulsed during a 2nd beat of req 2 -> all outputs are 0 the next cycle, and req 2 still valid is re-granted from a search starting at ptr 0.
REQ-038 Scenario 6: i_ready=0 for 3 cycles with TimeoutCycles=4 and owner valid=1 -> no timeout, the beat transfers when i_ready rises, and the counter clears.

Source files
------------

// File: rtl/europa_req_arbiter_pkg.sv
// Shared types and defaults for the europa request arbiter.
package europa_req_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int DefNumReq        = 4;
  localparam int DefDataWidth     = 64;
  localparam int DefTimeoutCycles = 255;

  // Index addition modulo n; both operands are assumed to be below n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/europa_rr_picker.sv
// Combinational round-robin search: first asserted request at or above ptr, with wrap.
module europa_rr_picker
  import europa_req_arbiter_pkg::*;
#(
  parameter int NumReq = DefNumReq,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic              valid,
  output logic [IdxW-1:0]   index
);

  // Scan from the farthest offset down so the nearest hit to ptr is assigned last.
  always_comb begin
    valid = |req;
    index = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (req[wrap_add(int'(ptr), k, NumReq)]) begin
        index = IdxW'(wrap_add(int'(ptr), k, NumReq));
      end
    end
  end

endmodule

// File: rtl/europa_req_arbiter.sv
// Round-robin arbiter granting a shared beat stream to one requester per transaction,
// with a stall timeout that forces release of a hung owner.
//
//   state | meaning
//   IDLE  | no owner; pick a winner from ptr when any request is valid
//   LOCK  | owner routed to the shared port until last beat or timeout
module europa_req_arbiter
  import europa_req_arbiter_pkg::*;
#(
  parameter int NumReq        = DefNumReq,
  parameter int DataWidth     = DefDataWidth,
  parameter int TimeoutCycles = DefTimeoutCycles
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NumReq-1:0]                  i_req_valid,
  input  logic [NumReq-1:0][DataWidth-1:0]   i_req_data,
  input  logic [NumReq-1:0]                  i_req_last,
  output logic [NumReq-1:0]                  o_req_ready,
  output logic                               o_valid,
  output logic [DataWidth-1:0]               o_data,
  output logic                               o_last,
  input  logic                               i_ready,
  output logic [$clog2(NumReq)-1:0]          o_grant_idx,
  output logic                               o_busy,
  output logic                               o_timeout
);

  localparam int IdxW = $clog2(NumReq);
  // The counter never holds TimeoutCycles itself: the cycle it would get there releases.
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   stall_q, stall_d;
  logic              tmo_q, tmo_d;

  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic              lock_act;
  logic              own_valid;
  logic              own_last;
  logic              xfer;
  logic [IdxW-1:0]   ptr_after;

  europa_rr_picker #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_picker (
    .req   (i_req_valid),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Outputs are gated by reset so nothing is offered while reset is held.
  assign lock_act  = (state_q == LOCK) && !i_rst;
  assign own_valid = i_req_valid[owner_q];
  assign own_last  = i_req_last[owner_q];
  assign xfer      = lock_act && own_valid && i_ready;
  assign ptr_after = IdxW'(wrap_add(int'(owner_q), 1, NumReq));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    stall_d = stall_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = LOCK;
          owner_d = pick_idx;
          stall_d = '0;
        end
      end
      LOCK: begin
        if (xfer) begin
          stall_d = '0;
          if (own_last) begin
            state_d = IDLE;
            ptr_d   = ptr_after;
          end
        end else if (stall_q == CntW'(TimeoutCycles - 1)) begin
          state_d = IDLE;
          ptr_d   = ptr_after;
          tmo_d   = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    o_req_ready = '0;
    o_valid     = 1'b0;
    o_data      = '0;
    o_last      = 1'b0;
    o_grant_idx = '0;
    if (lock_act) begin
      o_req_ready[owner_q] = i_ready;
      o_valid              = own_valid;
      o_data               = i_req_data[owner_q];
      o_last               = own_last;
      o_grant_idx          = owner_q;
    end
  end

  assign o_busy    = lock_act;
  assign o_timeout = tmo_q && !i_rst;

endmodule

// File: tb/tb_europa_req_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a transaction-level model.
module tb_europa_req_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int TO = 4;

  logic                  clk;
  logic                  rst;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0][DW-1:0] req_data;
  logic [NR-1:0]         req_last;
  logic [NR-1:0]         req_ready;
  logic                  valid;
  logic [DW-1:0]         data;
  logic                  last;
  logic                  ready;
  logic [1:0]            grant_idx;
  logic                  busy;
  logic                  timeout;

  europa_req_arbiter #(
    .NumReq        (NR),
    .DataWidth     (DW),
    .TimeoutCycles (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_valid     (valid),
    .o_data      (data),
    .o_last      (last),
    .i_ready     (ready),
    .o_grant_idx (grant_idx),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Model: who owns the resource, where the next search starts, stalls since last progress.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_stall = 0;
  bit m_tmo = 1'b0;

  logic       s_busy;
  logic [1:0] s_grant;
  logic       s_tmo;
  logic [3:0] s_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit found;
    bit moved;
    int idx;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_stall = 0; m_tmo = 0;
    end else if (!m_busy) begin
      m_tmo = 0;
      found = 0;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (!found && req_valid[idx]) begin
          found = 1; m_owner = idx; m_busy = 1; m_stall = 0;
        end
      end
    end else begin
      m_tmo = 0;
      moved = req_valid[m_owner] && ready;
      if (moved && req_last[m_owner]) begin
        m_busy = 0; m_ptr = (m_owner + 1) % NR;
      end else if (!moved && m_stall + 1 == TO) begin
        m_busy = 0; m_ptr = (m_owner + 1) % NR; m_tmo = 1;
      end else if (moved) begin
        m_stall = 0;
      end else begin
        m_stall = m_stall + 1;
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    bit act;
    #2;
    act = m_busy && !rst;
    chk("busy", 32'(busy), 32'(act));
    chk("grant_idx", 32'(grant_idx), act ? m_owner : 0);
    chk("timeout", 32'(timeout), 32'(m_tmo && !rst));
    chk("valid", 32'(valid), act ? 32'(req_valid[m_owner]) : 0);
    chk("last", 32'(last), act ? 32'(req_last[m_owner]) : 0);
    chk("req_ready", 32'(req_ready), (act && ready) ? (1 << m_owner) : 0);
    chk("data", 32'(data), act ? 32'(req_data[m_owner]) : 0);
    s_busy = busy; s_grant = grant_idx; s_tmo = timeout; s_ready = req_ready;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [3:0] v, input logic [3:0] l, input logic r);
    req_valid = v;
    req_last  = l;
    ready     = r;
    for (int i = 0; i < NR; i++) req_data[i] = 16'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    set_in(4'b0000, 4'b0000, 1'b0);
    cycle();
    cycle();
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_grant", 32'(s_grant), 0);
    chk("rst_tmo", 32'(s_tmo), 0);

    // Two competing single-beat requesters alternate with a bubble between grants.
    rst = 1'b0;
    set_in(4'b0101, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i % 2 == 1) chk("s1_grant", 32'(s_grant), (i % 4 == 1) ? 0 : 2);
      else chk("s1_bubble", 32'(s_busy), 0);
    end

    // Multi-beat transaction keeps the grant until its last beat.
    rst = 1'b1; cycle(); rst = 1'b0;
    set_in(4'b1010, 4'b1000, 1'b1);
    cycle();
    for (int b = 0; b < 3; b++) begin
      req_last = (b == 2) ? 4'b1010 : 4'b1000;
      cycle();
      chk("s2_grant", 32'(s_grant), 1);
    end
    req_last = 4'b1000;
    cycle(); chk("s2_bubble", 32'(s_busy), 0);
    cycle(); chk("s2_next", 32'(s_grant), 3);
    set_in(4'b0000, 4'b0000, 1'b1); cycle();

    // Owner drops valid: forced release, pointer advances past it.
    rst = 1'b1; cycle(); rst = 1'b0;
    set_in(4'b0001, 4'b0001, 1'b1); cycle();
    req_valid = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      cycle();
      chk("s3_hold", 32'(s_busy), 1);
      chk("s3_no_tmo", 32'(s_tmo), 0);
    end
    req_valid = 4'b0011;
    cycle();
    chk("s3_tmo", 32'(s_tmo), 1);
    chk("s3_idle", 32'(s_busy), 0);
    cycle(); chk("s3_regrant", 32'(s_grant), 1);
    set_in(4'b0010, 4'b0010, 1'b1); cycle();
    set_in(4'b0000, 4'b0000, 1'b1); cycle();

    // Last beat lands on the cycle the stall count would hit the limit.
    set_in(4'b0001, 4'b0001, 1'b0); cycle();
    for (int s = 0; s < 3; s++) cycle();
    ready = 1'b1;
    cycle(); chk("s4_last_busy", 32'(s_busy), 1);
    set_in(4'b0000, 4'b0000, 1'b1);
    cycle();
    chk("s4_tmo", 32'(s_tmo), 0);
    chk("s4_idle", 32'(s_busy), 0);

    // Backpressure short of the limit, then a transfer restarts the count.
    set_in(4'b0010, 4'b0000, 1'b0); cycle();
    for (int s = 0; s < 3; s++) begin
      cycle(); chk("s6_hold", 32'(s_busy), 1);
    end
    ready = 1'b1;
    cycle();
    chk("s6_xfer", 32'(s_busy), 1);
    chk("s6_ready", 32'(s_ready), 32'h2);
    ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      cycle();
      chk("s6_noto_busy", 32'(s_busy), 1);
      chk("s6_noto_tmo", 32'(s_tmo), 0);
    end
    set_in(4'b0010, 4'b0010, 1'b1);
    cycle(); chk("s6_end", 32'(s_busy), 1);
    set_in(4'b0000, 4'b0000, 1'b1); cycle();

    // Reset in the middle of a transaction aborts it without a timeout.
    set_in(4'b0100, 4'b0000, 1'b1); cycle();
    cycle(); chk("s5_beat1", 32'(s_grant), 2);
    rst = 1'b1; cycle();
    chk("s5_rst_busy", 32'(s_busy), 0);
    rst = 1'b0; cycle();
    chk("s5_after_busy", 32'(s_busy), 0);
    chk("s5_after_tmo", 32'(s_tmo), 0);
    cycle(); chk("s5_regrant", 32'(s_grant), 2);
    set_in(4'b0100, 4'b0100, 1'b1); cycle();
    set_in(4'b0000, 4'b0000, 1'b1); cycle();

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
